// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and saturating-counter helpers for the fetch-stage hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FETCH_WAIT = 2'd1,
    LOAD_STALL = 2'd2,
    FLUSH      = 2'd3
  } ctrl_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection between the ID and EX stages; purely combinational.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_memread,
  output logic       hazard
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard = ex_memread & (ex_rt != REG_ZERO) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Advance/hold/bubble sequencing of PC, IF/ID and ID/EX for the fetch stage.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush/wait cycle counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned WAIT_TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_memread,
  input  logic       ex_branch_taken,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] ctrl_state,
  output logic       imem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] load_stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] fetch_wait_cnt
`endif
);

  localparam bit         FLUSH_EN     = (FLUSH_CYCLES > 0);
  localparam bit         STALL_EN     = (LOAD_STALL_CYCLES > 1);
  localparam logic [7:0] FLUSH_RELOAD = FLUSH_EN ? 8'(FLUSH_CYCLES - 1) : 8'd0;
  localparam logic [7:0] STALL_RELOAD = STALL_EN ? 8'(LOAD_STALL_CYCLES - 2) : 8'd0;
  localparam logic [7:0] WAIT_LIMIT   = 8'(WAIT_TIMEOUT);

  ctrl_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        hazard;

  hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_rt      (ex_rt),
    .ex_memread (ex_memread),
    .hazard     (hazard)
  );

  // Next-state and output decode; a taken branch overrides every state identically.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (ex_branch_taken) begin
      pc_we      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (FLUSH_EN) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            idex_flush = 1'b1;
            if (STALL_EN) begin
              state_d = LOAD_STALL;
              cnt_d   = STALL_RELOAD;
            end else begin
              state_d = RUN;
            end
          end else if (!imem_ack) begin
            ifid_flush = 1'b1;
            state_d    = FETCH_WAIT;
            cnt_d      = 8'd0;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_ack) begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            state_d = RUN;
          end else begin
            ifid_flush = 1'b1;
            cnt_d      = sat_inc8(cnt_q, WAIT_LIMIT);
            if (cnt_d == WAIT_LIMIT) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end
        end
        LOAD_STALL: begin
          idex_flush = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        FLUSH: begin
          pc_we      = imem_ack;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // State, counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign imem_req   = (state_q == RUN) || (state_q == FETCH_WAIT);
  assign ctrl_state = state_q;
  assign imem_err   = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] ls_cnt_q, fl_cnt_q, fw_cnt_q;
  logic        ls_act, fl_act, fw_act;

  assign ls_act = !ex_branch_taken &&
                  ((state_q == LOAD_STALL) || ((state_q == RUN) && hazard));
  assign fl_act = ex_branch_taken || (state_q == FLUSH);
  assign fw_act = (state_q == FETCH_WAIT);

  // Saturating per-condition cycle counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ls_cnt_q <= 16'd0;
      fl_cnt_q <= 16'd0;
      fw_cnt_q <= 16'd0;
    end else begin
      ls_cnt_q <= ls_act ? sat_inc16(ls_cnt_q) : ls_cnt_q;
      fl_cnt_q <= fl_act ? sat_inc16(fl_cnt_q) : fl_cnt_q;
      fw_cnt_q <= fw_act ? sat_inc16(fw_cnt_q) : fw_cnt_q;
    end
  end

  assign load_stall_cnt = ls_cnt_q;
  assign flush_cnt      = fl_cnt_q;
  assign fetch_wait_cnt = fw_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2, WAIT_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req;
  logic       imem_ack = 1'b1;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       id_uses_rt = 1'b0;
  logic [4:0] ex_rt = 5'd0;
  logic       ex_memread = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       pc_we, ifid_we, ifid_flush, idex_flush, imem_err;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] load_stall_cnt, flush_cnt, fetch_wait_cnt;
`endif

  pipe_hazard_ctrl #(
    .LOAD_STALL_CYCLES (3),
    .FLUSH_CYCLES      (2),
    .WAIT_TIMEOUT      (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_ack        (imem_ack),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rt           (ex_rt),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .ctrl_state      (ctrl_state),
    .imem_err        (imem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .load_stall_cnt  (load_stall_cnt),
    .flush_cnt       (flush_cnt),
    .fetch_wait_cnt  (fetch_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Expected vector layout: {ctrl_state, pc_we, ifid_we, ifid_flush, idex_flush, imem_req, imem_err}
  function automatic logic [7:0] E(input logic [1:0] st, input logic pc, input logic we,
                                   input logic ff, input logic df, input logic req, input logic err);
    return {st, pc, we, ff, df, req, err};
  endfunction

  task automatic step(input string nm, input logic rst_v, input logic ack_v,
                      input logic [4:0] rs_v, input logic [4:0] rt_v, input logic urt_v,
                      input logic [4:0] ert_v, input logic mr_v, input logic br_v,
                      input logic [7:0] exp_v);
    exp_t e;
    @(negedge clk);
    reset           = rst_v;
    imem_ack        = ack_v;
    id_rs           = rs_v;
    id_rt           = rt_v;
    id_uses_rt      = urt_v;
    ex_rt           = ert_v;
    ex_memread      = mr_v;
    ex_branch_taken = br_v;
    e.name = nm;
    e.exp  = exp_v;
    q.push_back(e);
  endtask

  // Monitor: sample mid-low-phase, well away from the rising edge.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {ctrl_state, pc_we, ifid_we, ifid_flush, idex_flush, imem_req, imem_err};
        checks++;
        if (act === e.exp) begin
          passes++;
        end else begin
          $display("FAIL %s: got %b expected %b (st,pc,we,iff,idf,req,err)", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    step("reset",        1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,1,1,0,0,1,0));
    step("run",          1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,1,1,0,0,1,0));
    step("r0load",       1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, E(2'd0,1,1,0,0,1,0));
    step("rt_nouse",     1'b0, 1'b1, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, E(2'd0,1,1,0,0,1,0));
    step("loaduse",      1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, E(2'd0,0,0,0,1,1,0));
    step("stall1",       1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, E(2'd2,0,0,0,1,0,0));
    step("stall2",       1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, E(2'd2,0,0,0,1,0,0));
    step("after_stall",  1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,1,1,0,0,1,0));
    step("loaduse_rt",   1'b0, 1'b1, 5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, E(2'd0,0,0,0,1,1,0));
    step("stall_br",     1'b0, 1'b1, 5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, E(2'd2,1,0,1,1,0,0));
    step("flush1",       1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd3,1,0,1,1,0,0));
    step("flush2_noack", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd3,0,0,1,1,0,0));
    step("br_haz",       1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, E(2'd0,1,0,1,1,1,0));
    step("flush_rebr",   1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, E(2'd3,1,0,1,1,0,0));
    step("flush_a",      1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd3,1,0,1,1,0,0));
    step("flush_b",      1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd3,1,0,1,1,0,0));
    step("run2",         1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,1,1,0,0,1,0));
    step("fw_enter",     1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,0,0,1,0,1,0));
    for (int i = 0; i < 3; i++) begin
      step($sformatf("fw%0d", i + 1), 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
           E(2'd1,0,0,1,0,1,0));
    end
    step("fw_ack",       1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd1,1,1,0,0,1,0));
    step("run3",         1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,1,1,0,0,1,0));
    step("to_enter",     1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,0,0,1,0,1,0));
    for (int i = 0; i < 4; i++) begin
      step($sformatf("to%0d", i + 1), 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
           E(2'd1,0,0,1,0,1,0));
    end
    step("to_sat",       1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd1,0,0,1,0,1,1));
    step("fw_br",        1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, E(2'd1,1,0,1,1,1,1));
    step("flush_err1",   1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd3,1,0,1,1,0,1));
    step("flush_err2",   1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd3,1,0,1,1,0,1));
    step("err_sticky",   1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,1,1,0,0,1,1));
    step("ls_enter",     1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, E(2'd0,0,0,0,1,1,1));
    step("ls_in",        1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, E(2'd2,0,0,0,1,0,1));
    step("rst_mid",      1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,1,1,0,0,1,0));
    step("post_rst",     1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E(2'd0,1,1,0,0,1,0));

    repeat (3) @(negedge clk);
    #5;
    checks++;
    if (q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
